chan_reg_bank: RTL and testbench
================================

# chan_reg_bank

Parametrised multi-channel register bank with a host request/response handshake and per-channel behaviour modes. It generalises the two-register host/dev loopback (host writes `wr`, device returns `rd = wr + 1`) to `NCHAN` channels of `WIDTH` bits. Each channel has a selectable mode: plain store, read-back-plus-one, free-running counter, or locked. It sits on the device side of an application register interface, behind a single host port.

## Interface

Parameters:
- `WIDTH`, default 8: data width of every channel register.
- `NCHAN`, default 4: number of channels; legal range 1..256.
- `CHW`, default `$clog2(NCHAN)` (minimum 1): channel index width. Derived; not overridden.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, 1: host request present.
- `req_ready`, output, 1: bank can accept a request this cycle.
- `req_op`, input, 2: operation code. 0 READ, 1 WRITE, 2 SETMODE, 3 CLEAR.
- `req_chan`, input, `CHW`: target channel.
- `req_data`, input, `WIDTH`: write data; for SETMODE, bits [1:0] give the mode.
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: host accepts the response.
- `rsp_data`, output, `WIDTH`: response data.
- `rsp_err`, output, 1: request rejected.
- `chan_q`, output, `NCHAN*WIDTH`: live register contents; channel k occupies bits [k*WIDTH +: WIDTH].

## Operation

State:
- `reg[k]`, `WIDTH` bits per channel.
- `mode[k]`, 2 bits per channel.
- One response slot holding `rsp_valid`, `rsp_data` and `rsp_err`.

Modes:
- 0 STORE: READ returns `reg`.
- 1 INC: READ returns `reg + 1`, truncated to `WIDTH` bits (all-ones wraps to 0). `reg` itself is unchanged.
- 2 COUNT: `reg` increments by 1 every cycle and wraps at 2^WIDTH. READ returns `reg`.
- 3 LOCK: READ returns `reg`. WRITE and CLEAR are rejected and leave `reg` unchanged.

Operations (each accepted request produces exactly one response):
- READ: data as given by the channel mode; `rsp_err = 0`.
- WRITE: `reg <= req_data`; `rsp_data = req_data`; `rsp_err = 0`. In LOCK mode: no write, `rsp_data = reg`, `rsp_err = 1`.
- SETMODE: `mode <= req_data[1:0]`; `rsp_data = reg`; `rsp_err = 0`. SETMODE is always allowed, including to leave LOCK.
- CLEAR: `reg <= 0`; `rsp_data = 0`; `rsp_err = 0`. In LOCK mode: rejected, `rsp_err = 1`.
- Channel out of range (`req_chan >= NCHAN`): no state change; `rsp_data = 0`; `rsp_err = 1`.

Simultaneous events:
- A WRITE or CLEAR to a COUNT channel overrides that cycle's increment; the next cycle counts from the new value.
- A READ of a COUNT channel returns the value before the increment in the acceptance cycle.
- SETMODE to COUNT takes effect the cycle after acceptance; leaving COUNT freezes `reg` at the value after the acceptance-cycle increment.

## Timing

- Acceptance: a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_ready = !rsp_valid || rsp_ready`. This is combinational from `rsp_ready` and `rsp_valid` only, never from `req_valid`.
- Latency: the response appears one cycle after acceptance. `rsp_valid`, `rsp_data` and `rsp_err` rise at the edge that accepts the request.
- Hold: the response holds stable while `rsp_valid && !rsp_ready`; no new request is accepted during that time.
- Retire: the response retires at an edge where `rsp_ready = 1`. A request can be accepted at the same edge, and its response replaces the old one. With `rsp_ready` held high, throughput is 1 request per cycle.
- State update: register and mode updates take effect at the acceptance edge. `chan_q` reflects them the following cycle.
- Reset: all `reg` = 0, all `mode` = STORE, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, so `req_ready` = 1 and `chan_q` = 0.
- Reset mid-operation: any held response is discarded, and a request presented during reset is not accepted. COUNT channels stop and return to 0.

## Test plan

- Reset, then WRITE ch0=0xAB and READ ch0 with `rsp_ready=1` -> responses 0xAB/err0 and 0xAB/err0 on consecutive cycles; `chan_q[7:0]` = 0xAB.
- SETMODE ch1=INC, WRITE ch1=0xFF, READ ch1 -> read returns 0x00 (wrap); `chan_q` ch1 stays 0xFF.
- SETMODE ch2=COUNT after CLEAR, wait 10 cycles, WRITE ch2=0x50 -> `chan_q` ch2 counts 1..10, then reads 0x50 the cycle after the write and 0x51 the cycle after that.
- SETMODE ch3=LOCK, WRITE ch3=0x12 -> `rsp_err=1` with `rsp_data` = prior value; CLEAR ch3 also gives `rsp_err=1`; SETMODE ch3=STORE, then WRITE succeeds.
- Back-pressure: hold `rsp_ready=0` for 3 cycles with `req_valid=1` -> `req_ready=0`, response stable; release -> responses drain 1 per cycle in order with none lost.
- `NCHAN=3`, request ch3 -> `rsp_err=1`, `rsp_data=0`, `chan_q` unchanged. Separately, assert `rst` with a response pending -> `rsp_valid=0` next cycle and all channels 0.

Source files
------------

// File: rtl/chan_reg_bank.sv
// Multi-channel register bank behind one host request/response port.
// Each channel is a WIDTH-bit register with a STORE / INC / COUNT / LOCK mode.
module chan_reg_bank #(
  parameter int WIDTH = 8,
  parameter int NCHAN = 4,
  parameter int CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [CHW-1:0]         req_chan,
  input  logic [WIDTH-1:0]       req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic [NCHAN*WIDTH-1:0] chan_q
);

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_SETMODE = 2'd2;
  localparam logic [1:0] OP_CLEAR   = 2'd3;

  localparam logic [1:0] MODE_STORE = 2'd0;
  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_LOCK  = 2'd3;

  localparam logic [CHW:0] NCHAN_W = (CHW+1)'(NCHAN);

  logic [WIDTH-1:0] regs [NCHAN];
  logic [1:0]       mode [NCHAN];

  logic             accept;
  logic             chan_ok;
  logic [WIDTH-1:0] cur_reg;
  logic [1:0]       cur_mode;
  logic [WIDTH-1:0] rsp_data_d;
  logic             rsp_err_d;
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;
  logic             mode_en;

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // a response retires on a rising edge with rsp_valid && rsp_ready. The single
  // response slot frees up in the same cycle it retires, so req_ready depends only
  // on rsp_valid/rsp_ready, never on req_valid.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign chan_ok   = {1'b0, req_chan} < NCHAN_W;

  always_comb begin
    cur_reg  = '0;
    cur_mode = MODE_STORE;
    for (int k = 0; k < NCHAN; k++) begin
      if (req_chan == CHW'(k)) begin
        cur_reg  = regs[k];
        cur_mode = mode[k];
      end
    end
  end

  // Response and side effects of the presented request, applied only on accept.
  always_comb begin
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    wr_en      = 1'b0;
    wr_val     = '0;
    mode_en    = 1'b0;
    if (!chan_ok) begin
      rsp_err_d = 1'b1;
    end else begin
      case (req_op)
        OP_READ: begin
          rsp_data_d = (cur_mode == MODE_INC) ? cur_reg + WIDTH'(1) : cur_reg;
        end
        OP_WRITE: begin
          if (cur_mode == MODE_LOCK) begin
            rsp_data_d = cur_reg;
            rsp_err_d  = 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_val     = req_data;
            rsp_data_d = req_data;
          end
        end
        OP_SETMODE: begin
          mode_en    = 1'b1;
          rsp_data_d = cur_reg;
        end
        default: begin
          if (cur_mode == MODE_LOCK) begin
            rsp_data_d = cur_reg;
            rsp_err_d  = 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_val     = '0;
            rsp_data_d = '0;
          end
        end
      endcase
    end
  end

  // A host write later in this block overrides the same-cycle COUNT increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCHAN; k++) begin
        regs[k] <= '0;
        mode[k] <= MODE_STORE;
      end
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      for (int k = 0; k < NCHAN; k++) begin
        if (mode[k] == MODE_COUNT) begin
          regs[k] <= regs[k] + WIDTH'(1);
        end
        if (accept && wr_en && (req_chan == CHW'(k))) begin
          regs[k] <= wr_val;
        end
        if (accept && mode_en && (req_chan == CHW'(k))) begin
          mode[k] <= req_data[1:0];
        end
      end
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rsp_data_d;
        rsp_err   <= rsp_err_d;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan_q
    assign chan_q[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_chan_reg_bank.sv
// Randomised and directed bench for chan_reg_bank against an array-based model
// of the channel registers, modes and the single response slot.
module tb_chan_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_chan;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [31:0] chan_q;

  logic        b_req_valid;
  logic        b_req_ready;
  logic [1:0]  b_req_op;
  logic [1:0]  b_req_chan;
  logic [7:0]  b_req_data;
  logic        b_rsp_valid;
  logic        b_rsp_ready;
  logic [7:0]  b_rsp_data;
  logic        b_rsp_err;
  logic [23:0] b_chan_q;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_reg  [4];
  logic [1:0] m_mode [4];
  bit         m_rv;
  bit         m_re;
  logic [7:0] m_rd;
  bit         m_acc;
  logic [8:0] exp_q [$];

  chan_reg_bank #(.WIDTH(8), .NCHAN(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_chan(req_chan), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .chan_q(chan_q)
  );

  chan_reg_bank #(.WIDTH(8), .NCHAN(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_chan(b_req_chan), .req_data(b_req_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_err(b_rsp_err), .chan_q(b_chan_q)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  function automatic logic [31:0] exp_chan_q();
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = m_reg[k];
    return v;
  endfunction

  // One clock cycle: update the model from the presented inputs, then step the DUT.
  task automatic tick();
    logic [7:0] nd;
    bit ne;
    int ch;
    nd = 8'd0;
    ne = 1'b0;
    ch = int'(req_chan);
    m_acc = !rst && req_valid && (!m_rv || rsp_ready);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_reg[k]  = 8'd0;
        m_mode[k] = 2'd0;
      end
      m_rv = 1'b0;
      m_rd = 8'd0;
      m_re = 1'b0;
    end else begin
      if (m_acc) begin
        case (req_op)
          2'd0: nd = (m_mode[ch] == 2'd1) ? m_reg[ch] + 8'd1 : m_reg[ch];
          2'd1: if (m_mode[ch] == 2'd3) begin nd = m_reg[ch]; ne = 1'b1; end
                else nd = req_data;
          2'd2: nd = m_reg[ch];
          default: if (m_mode[ch] == 2'd3) begin nd = m_reg[ch]; ne = 1'b1; end
                   else nd = 8'd0;
        endcase
      end
      for (int k = 0; k < 4; k++)
        if (m_mode[k] == 2'd2) m_reg[k] = m_reg[k] + 8'd1;
      if (m_acc) begin
        case (req_op)
          2'd1: if (m_mode[ch] != 2'd3) m_reg[ch] = req_data;
          2'd2: m_mode[ch] = req_data[1:0];
          2'd3: if (m_mode[ch] != 2'd3) m_reg[ch] = 8'd0;
          default: ;
        endcase
        m_rv = 1'b1;
        m_rd = nd;
        m_re = ne;
        exp_q.push_back({ne, nd});
      end else if (rsp_ready) begin
        m_rv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_chan  = ch;
    req_data  = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b d=%h e=%b want v=0 d=00 e=0", rsp_valid, rsp_data, rsp_err);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    checks++;
    if (chan_q !== 32'd0 || b_chan_q !== 24'd0) begin
      errors++;
      $display("FAIL reset_chan_q: got %h/%h want 0", chan_q, b_chan_q);
    end
  endtask

  task automatic test_store();
    send(2'd1, 2'd0, 8'hAB);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hAB || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL store_write_rsp: got v=%b d=%h e=%b want v=1 d=ab e=0", rsp_valid, rsp_data, rsp_err);
    end
    send(2'd0, 2'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hAB || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL store_read_rsp: got v=%b d=%h e=%b want v=1 d=ab e=0", rsp_valid, rsp_data, rsp_err);
    end
    checks++;
    if (chan_q[7:0] !== 8'hAB) begin
      errors++;
      $display("FAIL store_chan_q: got %h want ab", chan_q[7:0]);
    end
  endtask

  task automatic test_inc();
    send(2'd2, 2'd1, 8'd1);
    send(2'd1, 2'd1, 8'hFF);
    send(2'd0, 2'd1, 8'h00);
    checks++;
    if (rsp_data !== 8'h00 || rsp_err !== 1'b0 || rsp_data !== m_rd) begin
      errors++;
      $display("FAIL inc_wrap_read: got d=%h e=%b want d=00 e=0", rsp_data, rsp_err);
    end
    checks++;
    if (chan_q[15:8] !== 8'hFF) begin
      errors++;
      $display("FAIL inc_chan_q: got %h want ff", chan_q[15:8]);
    end
  endtask

  task automatic test_count();
    send(2'd3, 2'd2, 8'd0);
    send(2'd2, 2'd2, 8'd2);
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (chan_q[23:16] !== 8'(i) || chan_q !== exp_chan_q()) begin
        errors++;
        $display("FAIL count_step%0d: got %h want %h", i, chan_q[23:16], 8'(i));
      end
    end
    send(2'd1, 2'd2, 8'h50);
    checks++;
    if (chan_q[23:16] !== 8'h50) begin
      errors++;
      $display("FAIL count_write: got %h want 50", chan_q[23:16]);
    end
    tick();
    checks++;
    if (chan_q[23:16] !== 8'h51) begin
      errors++;
      $display("FAIL count_after_write: got %h want 51", chan_q[23:16]);
    end
    send(2'd0, 2'd2, 8'h00);
    checks++;
    if (rsp_data !== 8'h51 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL count_read_pre_inc: got d=%h e=%b want d=51 e=0", rsp_data, rsp_err);
    end
    send(2'd2, 2'd2, 8'd0);
    tick();
    tick();
    checks++;
    if (chan_q[23:16] !== 8'h53 || chan_q !== exp_chan_q()) begin
      errors++;
      $display("FAIL count_freeze: got %h want 53", chan_q[23:16]);
    end
  endtask

  task automatic test_lock();
    send(2'd1, 2'd3, 8'h34);
    send(2'd2, 2'd3, 8'd3);
    send(2'd1, 2'd3, 8'h12);
    checks++;
    if (rsp_err !== 1'b1 || rsp_data !== 8'h34) begin
      errors++;
      $display("FAIL lock_write: got d=%h e=%b want d=34 e=1", rsp_data, rsp_err);
    end
    send(2'd3, 2'd3, 8'h00);
    checks++;
    if (rsp_err !== 1'b1 || chan_q[31:24] !== 8'h34) begin
      errors++;
      $display("FAIL lock_clear: got e=%b q=%h want e=1 q=34", rsp_err, chan_q[31:24]);
    end
    send(2'd2, 2'd3, 8'd0);
    send(2'd1, 2'd3, 8'h12);
    checks++;
    if (rsp_err !== 1'b0 || rsp_data !== 8'h12 || chan_q[31:24] !== 8'h12) begin
      errors++;
      $display("FAIL unlock_write: got d=%h e=%b q=%h want d=12 e=0 q=12", rsp_data, rsp_err, chan_q[31:24]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [8];
    logic [1:0] chs [8];
    logic [7:0] dat [8];
    logic [8:0] exp;
    logic [7:0] held;
    int idx;
    int drained;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    tick();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      ops[i] = 2'($urandom_range(0, 1));
      chs[i] = 2'($urandom_range(0, 3));
      dat[i] = 8'($urandom_range(0, 255));
    end
    idx = 0;
    drained = 0;
    held = 8'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (idx >= 8 && !rsp_valid) break;
      req_valid = (idx < 8);
      if (idx < 8) begin
        req_op   = ops[idx];
        req_chan = chs[idx];
        req_data = dat[idx];
      end
      rsp_ready = (cyc >= 4);
      if (rsp_valid && rsp_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        drained++;
        checks++;
        if ({rsp_err, rsp_data} !== exp) begin
          errors++;
          $display("FAIL b2b_drain%0d: got e=%b d=%h want e=%b d=%h", drained, rsp_err, rsp_data, exp[8], exp[7:0]);
        end
      end
      tick();
      if (m_acc) idx++;
      if (cyc == 0) held = rsp_data;
      if (cyc >= 1 && cyc <= 3) begin
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== held) begin
          errors++;
          $display("FAIL b2b_hold%0d: got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", cyc, req_ready, rsp_valid, rsp_data, held);
        end
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    checks++;
    if (drained != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: drained %0d left %0d want 8 and 0", drained, exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_op    = 2'($urandom_range(0, 3));
      req_chan  = 2'($urandom_range(0, 3));
      req_data  = 8'($urandom_range(0, 255));
      tick();
      checks++;
      if (rsp_valid !== m_rv || (m_rv && (rsp_data !== m_rd || rsp_err !== m_re))) begin
        errors++;
        $display("FAIL random_rsp%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b", i, rsp_valid, rsp_data, rsp_err, m_rv, m_rd, m_re);
      end
      checks++;
      if (chan_q !== exp_chan_q() || req_ready !== (!m_rv || rsp_ready)) begin
        errors++;
        $display("FAIL random_state%0d: got q=%h rdy=%b want q=%h rdy=%b", i, chan_q, req_ready, exp_chan_q(), !m_rv || rsp_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_bad_chan();
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    b_req_op    = 2'd1;
    b_req_chan  = 2'd0;
    b_req_data  = 8'h77;
    @(posedge clk); #1;
    b_req_chan = 2'd3;
    b_req_data = 8'h99;
    @(posedge clk); #1;
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1 || b_rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL bad_chan_write: got v=%b d=%h e=%b want v=1 d=00 e=1", b_rsp_valid, b_rsp_data, b_rsp_err);
    end
    b_req_op = 2'd0;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    checks++;
    if (b_rsp_err !== 1'b1 || b_rsp_data !== 8'h00 || b_chan_q !== 24'h000077) begin
      errors++;
      $display("FAIL bad_chan_read: got d=%h e=%b q=%h want d=00 e=1 q=000077", b_rsp_data, b_rsp_err, b_chan_q);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    send(2'd2, 2'd0, 8'd2);
    rsp_ready = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pending: got v=%b want 1", rsp_valid);
    end
    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_chan  = 2'd1;
    req_data  = 8'h55;
    tick();
    rst       = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || chan_q !== 32'd0 || b_chan_q !== 24'd0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b q=%h/%h want v=0 q=0", rsp_valid, chan_q, b_chan_q);
    end
    tick();
    tick();
    checks++;
    if (chan_q !== 32'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: got q=%h rdy=%b want q=0 rdy=1", chan_q, req_ready);
    end
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_op      = 2'd0;
    req_chan    = 2'd0;
    req_data    = 8'd0;
    rsp_ready   = 1'b1;
    b_req_valid = 1'b0;
    b_req_op    = 2'd0;
    b_req_chan  = 2'd0;
    b_req_data  = 8'd0;
    b_rsp_ready = 1'b1;
    m_rv = 1'b0;
    m_re = 1'b0;
    m_rd = 8'd0;
    for (int k = 0; k < 4; k++) begin
      m_reg[k]  = 8'd0;
      m_mode[k] = 2'd0;
    end
    test_reset();
    test_store();
    test_inc();
    test_count();
    test_lock();
    test_back_to_back();
    test_random();
    test_bad_chan();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
